// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, one WIDTH+1-bit add per clock.
// Valid/ready on both sides; product is registered and held until taken.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   sum;

    // Carry out lands in sum[WIDTH] and becomes acc's MSB after the shift.
    always_comb begin
        sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            acc       <= '0;
            mq        <= '0;
            mcand     <= '0;
            count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a;
                        mq       <= b;
                        acc      <= '0;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= sum[WIDTH:1];
                    mq    <= {sum[0], mq[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state     <= DONE;
                        count     <= '0;
                        out_valid <= 1'b1;
                        product   <= {sum, mq[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        product   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    product   <= '0;
                    count     <= '0;
                end
            endcase
        end
    end

endmodule
